// File: rtl/queue_ctrl_if.sv
// queue_ctrl_if: user controls, status and register-file ports of queue_ctrl.
// master = user/register-file side, slave = queue controller.
interface queue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             en_in;
  logic [WIDTH-1:0] din;
  logic             en_out;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [5:0]       count;
  logic             ovf;
  logic             udf;
  logic [4:0]       rf_wa;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wd;
  logic [4:0]       rf_ra0;
  logic [WIDTH-1:0] rf_rd0;
  logic [4:0]       rf_ra1;
  logic [WIDTH-1:0] rf_rd1;
  logic [4:0]       scan_addr;
  logic [WIDTH-1:0] scan_data;
  logic             scan_valid;

  modport master (
    output en_in, din, en_out, rf_rd0, rf_rd1,
    input  dout, full, empty, count, ovf, udf,
    input  rf_wa, rf_we, rf_wd, rf_ra0, rf_ra1,
    input  scan_addr, scan_data, scan_valid
  );

  modport slave (
    input  en_in, din, en_out, rf_rd0, rf_rd1,
    output dout, full, empty, count, ovf, udf,
    output rf_wa, rf_we, rf_wd, rf_ra0, rf_ra1,
    output scan_addr, scan_data, scan_valid
  );
endinterface

// File: rtl/queue_ctrl.sv
// queue_ctrl: FIFO controller over an external 32-entry register file.
// Define QUEUE_CTRL_EDGE_DET_EN for synchronised, edge-detected push/pop.
module queue_ctrl #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int SCAN_DIV = 4
) (
  input logic         clk,
  input logic         rst,
  queue_ctrl_if.slave q
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [4:0]       head, tail, sp;
  logic [5:0]       cnt, off;
  logic [DW-1:0]    div;
  logic [WIDTH-1:0] dout_r;
  logic             ovf_r, udf_r;
  logic             push, pop, push_ok, pop_ok;
  logic             is_full, is_empty, sp_ok;

`ifdef QUEUE_CTRL_EDGE_DET_EN
  logic [1:0] si, so;
  logic       pi, po;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      si <= '0;
      so <= '0;
      pi <= 1'b0;
      po <= 1'b0;
    end else begin
      si <= {si[0], q.en_in};
      so <= {so[0], q.en_out};
      pi <= si[1];
      po <= so[1];
    end
  end

  assign push = si[1] & ~pi;
  assign pop  = so[1] & ~po;
`else
  assign push = q.en_in;
  assign pop  = q.en_out;
`endif

  function automatic logic [4:0] inc(
    input logic [4:0] p
  );
    return (p == 5'(DEPTH - 1)) ? 5'd0 : p + 5'd1;
  endfunction

  assign is_full  = (cnt == 6'(DEPTH));
  assign is_empty = (cnt == 6'd0);
  assign push_ok  = push && (!is_full || pop);
  assign pop_ok   = pop && !is_empty;

  assign q.full       = is_full;
  assign q.empty      = is_empty;
  assign q.count      = cnt;
  assign q.dout       = dout_r;
  assign q.ovf        = ovf_r;
  assign q.udf        = udf_r;
  // a write edge coinciding with reset must not reach the array
  assign q.rf_we      = push_ok && !rst;
  assign q.rf_wa      = tail;
  assign q.rf_wd      = q.din;
  assign q.rf_ra0     = head;
  assign q.rf_ra1     = sp;
  assign q.scan_addr  = sp;
  assign q.scan_data  = q.rf_rd1;
  assign q.scan_valid = !is_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      dout_r <= '0;
      ovf_r  <= 1'b0;
      udf_r  <= 1'b0;
    end else begin
      if (push_ok)
        tail <= inc(tail);
      if (pop_ok) begin
        head   <= inc(head);
        dout_r <= q.rf_rd0;
      end
      cnt   <= cnt + 6'(push_ok) - 6'(pop_ok);
      ovf_r <= push && !push_ok;
      udf_r <= pop && !pop_ok;
    end
  end

  // distance of the scan slot from head, modulo DEPTH
  always_comb begin
    off = {1'b0, sp} - {1'b0, head};
    if (sp < head)
      off = {1'b0, sp} + 6'(DEPTH) - {1'b0, head};
  end

  assign sp_ok = (off < cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp  <= '0;
      div <= '0;
    end else if (is_empty || !sp_ok) begin
      sp  <= head;
      div <= '0;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      sp  <= (off + 6'd1 >= cnt) ? head : inc(sp);
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: tb/tb_queue_ctrl.sv
// tb_queue_ctrl: scoreboard bench for queue_ctrl with a queue-based model.
// Level-request build (QUEUE_CTRL_EDGE_DET_EN undefined).
module tb_queue_ctrl;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int SD = 4;

  typedef struct {
    logic         we;
    logic [4:0]   wa;
    logic [W-1:0] wd;
    logic [4:0]   ra0;
    logic [W-1:0] dout;
    logic [5:0]   cnt;
    logic         ovf;
    logic         udf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  queue_ctrl_if #(.WIDTH(W)) q();

  queue_ctrl #(
    .WIDTH(W),
    .DEPTH(D),
    .SCAN_DIV(SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q(q)
  );

  logic [W-1:0] mem [32];
  always @(posedge clk)
    if (q.rf_we) mem[q.rf_wa] <= q.rf_wd;
  assign q.rf_rd0 = mem[q.rf_ra0];
  assign q.rf_rd1 = mem[q.rf_ra1];

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  exp_t sb[$];
  exp_t me;

  logic [W-1:0] mq[$];
  int           mhead, mtail;
  logic [W-1:0] mdout;
  bit           movf, mudf;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic mreset();
    mq.delete();
    mhead = 0;
    mtail = 0;
    mdout = '0;
    movf  = 1'b0;
    mudf  = 1'b0;
  endtask

  // drive one cycle; record what the DUT must show during it
  task automatic step(input bit p, input bit o, input logic [W-1:0] d);
    exp_t e;
    bit   pok, ook;
    q.en_in  = p;
    q.en_out = o;
    q.din    = d;
    pok = p && (mq.size() < D || o);
    ook = o && mq.size() > 0;
    e.we   = pok;
    e.wa   = 5'(mtail);
    e.wd   = d;
    e.ra0  = 5'(mhead);
    e.dout = mdout;
    e.cnt  = 6'(mq.size());
    e.ovf  = movf;
    e.udf  = mudf;
    sb.push_back(e);
    if (ook) begin
      mdout = mq.pop_front();
      mhead = (mhead + 1) % D;
    end
    if (pok) begin
      mq.push_back(d);
      mtail = (mtail + 1) % D;
    end
    movf = p && !pok;
    mudf = o && !ook;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    chk_en   = 1'b0;
    q.en_in  = 1'b0;
    q.en_out = 1'b0;
    rst      = 1'b1;
    mreset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en && sb.size() != 0) begin
      me = sb.pop_front();
      chk("rf_we", q.rf_we, me.we);
      chk("rf_wa", q.rf_wa, me.wa);
      chk("rf_wd", q.rf_wd, me.wd);
      chk("rf_ra0", q.rf_ra0, me.ra0);
      chk("dout", q.dout, me.dout);
      chk("count", q.count, me.cnt);
      chk("full", q.full, me.cnt == 6'(D));
      chk("empty", q.empty, me.cnt == 6'd0);
      chk("ovf", q.ovf, me.ovf);
      chk("udf", q.udf, me.udf);
      chk("scan_valid", q.scan_valid, me.cnt != 6'd0);
      chk("scan_data", q.scan_data, mem[q.scan_addr]);
    end
  end

  int ra[$];
  int rl[$];
  int nxt;

  initial begin
    q.en_in  = 1'b0;
    q.en_out = 1'b0;
    q.din    = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    q.en_in = 1'b1;
    q.din   = 32'hDEAD;
    #1;
    chk("rst_count", q.count, 0);
    chk("rst_empty", q.empty, 1);
    chk("rst_full", q.full, 0);
    chk("rst_rf_we", q.rf_we, 0);
    chk("rst_scan_valid", q.scan_valid, 0);
    chk("rst_scan_addr", q.scan_addr, 0);
    chk("rst_dout", q.dout, 0);
    chk("rst_ovf", q.ovf, 0);
    chk("rst_udf", q.udf, 0);
    q.en_in = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    step(1, 0, 32'h11);
    step(1, 0, 32'h22);
    step(1, 0, 32'h33);
    step(0, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < D; i++)
      step(1, 0, 32'h100 + i);
    step(1, 0, 32'h99);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 1, 32'hAA);
    step(0, 0, 0);
    repeat (D) step(0, 1, 0);
    step(1, 1, 32'h55);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    // scan over 3 entries starting at head 6
    pulse_reset();
    repeat (6) step(1, 0, $urandom);
    repeat (6) step(0, 1, 0);
    step(0, 0, 0);
    chk("scan_idle_addr", q.scan_addr, 6);
    chk("scan_idle_valid", q.scan_valid, 0);
    step(1, 0, 32'hA1);
    step(1, 0, 32'hB2);
    step(1, 0, 32'hC3);
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0);
      if (ra.size() == 0 || ra[ra.size() - 1] != int'(q.scan_addr)) begin
        ra.push_back(int'(q.scan_addr));
        rl.push_back(1);
      end else begin
        rl[rl.size() - 1]++;
      end
    end
    chk("scan_runs", ra.size() >= 4, 1);
    for (int i = 1; i < ra.size(); i++) begin
      nxt = (ra[i - 1] == 6) ? 7 : (ra[i - 1] == 7) ? 0 : 6;
      chk("scan_seq", ra[i], nxt);
    end
    for (int i = 1; i < ra.size() - 1; i++)
      chk("scan_hold", rl[i], SD);

    // reset mid-scan with a push pending
    chk_en  = 1'b0;
    q.en_in = 1'b1;
    q.din   = 32'hBEEF;
    rst     = 1'b1;
    #1;
    chk("mid_rst_scan_valid", q.scan_valid, 0);
    chk("mid_rst_count", q.count, 0);
    chk("mid_rst_empty", q.empty, 1);
    chk("mid_rst_rf_we", q.rf_we, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_nowrite", mem[0], 32'hC3);
    q.en_in = 1'b0;
    rst = 1'b0;
    mreset();
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    for (int i = 0; i < 600; i++) begin
      if ((i / 40) % 2 == 0)
        step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 30,
             $urandom);
      else
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 75,
             $urandom);
    end
    step(0, 0, 0);

    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
